// File: rtl/game_countdown_pkg.sv
// Shared definitions for the game countdown timer.
// Holds the 2-bit FSM state encoding, the BCD digit limits and a
// helper that clamps an out-of-range BCD digit to 9.
package game_countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction

endpackage

// File: rtl/game_countdown_tick.sv
// One-second tick divider for the game countdown.
// Ports:
//   Clock     - rising-edge clock
//   Reset     - synchronous active-high reset, loads CLOCK_FREQUENCY-1
//   Run       - counter advances only while high
//   ReloadReq - reload to CLOCK_FREQUENCY-1 (start of a fresh countdown)
//   Tick      - one-cycle pulse every CLOCK_FREQUENCY running cycles
// While Run is low the count simply holds, so a paused countdown resumes
// with the remainder of the interrupted second.
module countdown_tick #(
    parameter int CLOCK_FREQUENCY = 50000000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Run,
    input  logic ReloadReq,
    output logic Tick
);

    localparam int W = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
    localparam logic [W-1:0] RELOAD = W'(CLOCK_FREQUENCY - 1);

    logic [W-1:0] count;

    assign Tick = Run && (count == '0);

    always_ff @(posedge Clock) begin
        if (Reset || ReloadReq) begin
            count <= RELOAD;
        end else if (Run) begin
            count <= (count == '0) ? RELOAD : count - W'(1);
        end
    end

endmodule

// File: rtl/game_countdown.sv
// Game countdown timer: a two-digit BCD value counting down once per second.
// Ports:
//   Clock, Reset         - rising-edge clock, synchronous active-high reset
//   Load/LoadTens/LoadOnes - load a new BCD value (digits above 9 clamp to 9)
//   Start, Pause         - begin/resume and freeze the countdown
//   TensValue/OnesValue  - current BCD digits; game_timer = {tens, ones}
//   Running              - high while in RUN
//   Expired              - one-cycle pulse when the count reaches 00
//   TimeUp               - level, high while in DONE
// Command priority is Reset > Load > Start > Pause.
//
// state  | meaning
// IDLE   | value loaded/reset, waiting for Start
// RUN    | counting down, one decrement per divider tick
// PAUSED | frozen; divider holds its partial second
// DONE   | reached 00; only Load or Reset leaves
module game_countdown
    import game_countdown_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int INIT_TENS       = 6,
    parameter int INIT_ONES       = 0
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Load,
    input  logic [3:0] LoadTens,
    input  logic [3:0] LoadOnes,
    input  logic       Start,
    input  logic       Pause,
    output logic [3:0] TensValue,
    output logic [3:0] OnesValue,
    output logic [7:0] game_timer,
    output logic       Running,
    output logic       Expired,
    output logic       TimeUp
);

    state_t     state;
    logic       tick;
    logic       run_en;
    logic       reload_req;
    logic       value_zero;
    logic       dec_zero;
    logic [3:0] tens_dec;
    logic [3:0] ones_dec;

    assign game_timer = {TensValue, OnesValue};
    assign value_zero = (TensValue == BCD_ZERO) && (OnesValue == BCD_ZERO);
    assign run_en     = (state == ST_RUN);
    // Only a fresh start from IDLE restarts the second; PAUSED->RUN resumes.
    assign reload_req = (state == ST_IDLE) && !Load && Start && !value_zero;

    countdown_tick #(
        .CLOCK_FREQUENCY(CLOCK_FREQUENCY)
    ) u_tick (
        .Clock    (Clock),
        .Reset    (Reset),
        .Run      (run_en),
        .ReloadReq(reload_req),
        .Tick     (tick)
    );

    // BCD decrement with borrow; holds at 00 rather than wrapping.
    always_comb begin
        tens_dec = TensValue;
        ones_dec = OnesValue;
        if (OnesValue != BCD_ZERO) begin
            ones_dec = OnesValue - 4'd1;
        end else if (TensValue != BCD_ZERO) begin
            ones_dec = BCD_MAX;
            tens_dec = TensValue - 4'd1;
        end
    end

    assign dec_zero = (tens_dec == BCD_ZERO) && (ones_dec == BCD_ZERO);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= ST_IDLE;
            TensValue <= 4'(INIT_TENS);
            OnesValue <= 4'(INIT_ONES);
            Running   <= 1'b0;
            Expired   <= 1'b0;
            TimeUp    <= 1'b0;
        end else begin
            Expired <= 1'b0;
            if (Load && state != ST_RUN) begin
                TensValue <= bcd_clamp(LoadTens);
                OnesValue <= bcd_clamp(LoadOnes);
                state     <= ST_IDLE;
                Running   <= 1'b0;
                TimeUp    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_PAUSED: begin
                        if (Start && !value_zero) begin
                            state   <= ST_RUN;
                            Running <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (tick) begin
                            TensValue <= tens_dec;
                            OnesValue <= ones_dec;
                        end
                        // Reaching 00 wins over a coincident Pause.
                        if (tick && dec_zero) begin
                            state   <= ST_DONE;
                            Running <= 1'b0;
                            Expired <= 1'b1;
                            TimeUp  <= 1'b1;
                        end else if (Pause) begin
                            state   <= ST_PAUSED;
                            Running <= 1'b0;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_DONE;
                    end
                    default: begin
                        state   <= ST_IDLE;
                        Running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_countdown.sv
// Directed bench for game_countdown with a 4-cycle second.
module tb_game_countdown;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Load = 1'b0;
    logic [3:0] LoadTens = 4'd0;
    logic [3:0] LoadOnes = 4'd0;
    logic       Start = 1'b0;
    logic       Pause = 1'b0;
    logic [3:0] TensValue;
    logic [3:0] OnesValue;
    logic [7:0] game_timer;
    logic       Running;
    logic       Expired;
    logic       TimeUp;

    game_countdown #(
        .CLOCK_FREQUENCY(4)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Load      (Load),
        .LoadTens  (LoadTens),
        .LoadOnes  (LoadOnes),
        .Start     (Start),
        .Pause     (Pause),
        .TensValue (TensValue),
        .OnesValue (OnesValue),
        .game_timer(game_timer),
        .Running   (Running),
        .Expired   (Expired),
        .TimeUp    (TimeUp)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string      tag;
        logic [7:0] val;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input string tag, input logic [7:0] val, input int lat);
        exp_t e;
        e.tag = tag;
        e.val = val;
        e.lat = lat;
        exp_q.push_back(e);
    endtask

    // Pops the next expected value, waits (bounded) for game_timer to move,
    // then checks both the new value and the cycles it took.
    task automatic sb_check();
        exp_t       e;
        int         c;
        logic [7:0] old;
        e   = exp_q.pop_front();
        old = game_timer;
        c   = 0;
        while (game_timer === old && c < 40) begin
            @(negedge Clock);
            c++;
        end
        chk({e.tag, "_val"}, game_timer, e.val);
        chk({e.tag, "_lat"}, 8'(c), 8'(e.lat));
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] o);
        Load = 1'b1; LoadTens = t; LoadOnes = o;
        @(negedge Clock);
        Load = 1'b0;
    endtask

    task automatic do_start();
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic do_pause();
        Pause = 1'b1;
        @(negedge Clock);
        Pause = 1'b0;
    endtask

    task automatic chk_flags(input string tag, input logic r, input logic e, input logic t);
        chk({tag, "_running"}, {7'd0, Running}, {7'd0, r});
        chk({tag, "_expired"}, {7'd0, Expired}, {7'd0, e});
        chk({tag, "_timeup"},  {7'd0, TimeUp},  {7'd0, t});
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge Clock);
        chk("rst_timer", game_timer, 8'h60);
        chk("rst_tens", {4'd0, TensValue}, 8'h06);
        chk("rst_ones", {4'd0, OnesValue}, 8'h00);
        chk_flags("rst", 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
        @(negedge Clock);

        // Basic countdown 60 -> 59 -> 58
        do_start();
        chk_flags("start60", 1'b1, 1'b0, 1'b0);
        push_exp("run59", 8'h59, 4);
        push_exp("run58", 8'h58, 4);
        sb_check();
        sb_check();

        // Load during RUN is ignored
        @(negedge Clock);
        do_load(4'd1, 4'd2);
        chk("load_in_run", game_timer, 8'h58);
        chk_flags("load_in_run", 1'b1, 1'b0, 1'b0);
        do_pause();
        chk("pause58", game_timer, 8'h58);
        chk_flags("pause58", 1'b0, 1'b0, 1'b0);

        // Load 10 and run to expiry
        do_load(4'd1, 4'd0);
        chk("load10", game_timer, 8'h10);
        do_start();
        for (int i = 9; i >= 0; i--) begin
            push_exp($sformatf("cnt%0d", i), 8'(i), 4);
        end
        for (int i = 0; i < 10; i++) begin
            sb_check();
        end
        chk_flags("expire", 1'b0, 1'b1, 1'b1);
        @(negedge Clock);
        chk_flags("after_expire", 1'b0, 1'b0, 1'b1);
        do_start();
        repeat (12) @(negedge Clock);
        chk("done_hold", game_timer, 8'h00);
        chk_flags("done_hold", 1'b0, 1'b0, 1'b1);

        // Clamp on load, Load beats Start
        do_load(4'hF, 4'd3);
        chk("clamp_f3", game_timer, 8'h93);
        chk_flags("clamp_f3", 1'b0, 1'b0, 1'b0);
        Start = 1'b1;
        do_load(4'd4, 4'hC);
        Start = 1'b0;
        chk("load_start", game_timer, 8'h49);
        chk_flags("load_start", 1'b0, 1'b0, 1'b0);

        // Pause mid-second keeps the partial second
        do_load(4'd2, 4'd5);
        do_start();
        @(negedge Clock);
        do_pause();
        chk_flags("pause25", 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge Clock);
        chk("pause25_hold", game_timer, 8'h25);
        do_pause();
        chk("pause_in_paused", game_timer, 8'h25);
        do_start();
        chk_flags("resume25", 1'b1, 1'b0, 1'b0);
        push_exp("resume24", 8'h24, 2);
        push_exp("resume23", 8'h23, 4);
        sb_check();
        sb_check();
        do_pause();

        // Start with 00 is ignored
        do_load(4'd0, 4'd0);
        do_start();
        chk_flags("start00", 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge Clock);
        chk("start00_hold", game_timer, 8'h00);

        // Pause coincident with tick reaching 00: DONE wins
        do_load(4'd0, 4'd1);
        do_start();
        repeat (3) @(negedge Clock);
        do_pause();
        chk("tickpause00", game_timer, 8'h00);
        chk_flags("tickpause00", 1'b0, 1'b1, 1'b1);

        // Pause coincident with a nonzero tick: decrement then PAUSED
        do_load(4'd1, 4'd2);
        do_start();
        repeat (3) @(negedge Clock);
        do_pause();
        chk("tickpause11", game_timer, 8'h11);
        chk_flags("tickpause11", 1'b0, 1'b0, 1'b0);
        do_start();
        push_exp("after_tp10", 8'h10, 4);
        sb_check();
        do_pause();

        // Reset mid-RUN, and Reset overriding Start
        do_load(4'd3, 4'd7);
        do_start();
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        chk("rst_midrun", game_timer, 8'h60);
        chk_flags("rst_midrun", 1'b0, 1'b0, 1'b0);
        Reset = 1'b1;
        Start = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        Start = 1'b0;
        chk_flags("rst_start", 1'b0, 1'b0, 1'b0);
        do_start();
        push_exp("post_rst59", 8'h59, 4);
        sb_check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/game_countdown.md
GAME_COUNTDOWN -- requirements
Module: game_countdown

Interface
REQ-001 The block SHALL have parameter CLOCK_FREQUENCY, default 50000000, meaning Clock cycles per one-second tick.
REQ-002 The block SHALL have parameter INIT_TENS, default 6, meaning the BCD tens digit applied at reset.
REQ-003 The block SHALL have parameter INIT_ONES, default 0, meaning the BCD ones digit applied at reset.
REQ-004 The block SHALL have port Clock, input, 1 bit: the clock; all logic is rising-edge.
REQ-005 The block SHALL have port Reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port Load, input, 1 bit: a single-cycle request to load LoadTens/LoadOnes.
REQ-007 The block SHALL have port LoadTens, input, 4 bits: the BCD tens digit to load.
REQ-008 The block SHALL have port LoadOnes, input, 4 bits: the BCD ones digit to load.
REQ-009 The block SHALL have port Start, input, 1 bit: begin or resume the countdown.
REQ-010 The block SHALL have port Pause, input, 1 bit: freeze the countdown.
REQ-011 The block SHALL have port TensValue, output, 4 bits: the current BCD tens digit.
REQ-012 The block SHALL have port OnesValue, output, 4 bits: the current BCD ones digit.
REQ-013 The block SHALL have port game_timer, output, 8 bits: {TensValue, OnesValue}.
REQ-014 The block SHALL have port Running, output, 1 bit: high while in state RUN.
REQ-015 The block SHALL have port Expired, output, 1 bit: a one-cycle pulse when the count reaches 00.
REQ-016 The block SHALL have port TimeUp, output, 1 bit: a level that is high while in state DONE.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, PAUSED and DONE, and all outputs SHALL be registered.
REQ-018 The tick divider SHALL count down from CLOCK_FREQUENCY-1 while in RUN and SHALL emit a one-cycle tick when it reaches 0, then reload, giving a period of exactly CLOCK_FREQUENCY cycles.
REQ-019 The divider SHALL reload to CLOCK_FREQUENCY-1 on the IDLE->RUN transition, hold its value in PAUSED and resume from that value on PAUSED->RUN, so there is no partial-second loss.
REQ-020 On a tick with OnesValue!=0, the block SHALL decrement ones.
REQ-021 On a tick with OnesValue==0 and TensValue!=0, the block SHALL set ones=9 and decrement tens (BCD borrow).
REQ-022 The tick that produces 00 SHALL cause, in the next cycle, value=00, state=DONE, Expired=1 for exactly one cycle, TimeUp=1 and Running=0.
REQ-023 Command priority SHALL be Reset > Load > Start > Pause.
REQ-024 Load SHALL be accepted in IDLE, PAUSED and DONE: the digits update the next cycle, the state goes to IDLE, and TimeUp is cleared.
REQ-025 Load SHALL be ignored in RUN.
REQ-026 A loaded digit greater than 9 SHALL be clamped to 9.
REQ-027 Start in IDLE or PAUSED SHALL enter RUN when the value is not 00.
REQ-028 Start with value 00 SHALL be ignored.
REQ-029 Start in RUN or DONE SHALL be a no-op.
REQ-030 Pause in RUN SHALL enter PAUSED; Pause in any other state SHALL be a no-op.
REQ-031 Start and Pause together in RUN SHALL result in PAUSED.
REQ-032 A tick coincident with Pause SHALL still decrement, and the state SHALL then be PAUSED.
REQ-033 If that coincident tick reaches 00, DONE SHALL take precedence over PAUSED.
REQ-034 DONE SHALL be exited only by Load or Reset.
REQ-035 The digits SHALL never leave the range 0-9, and no wrap below 00 SHALL occur.

Reset
REQ-036 Reset SHALL be synchronous and active-high, and SHALL take effect on the first rising Clock edge at which it is sampled high, including mid-RUN and mid-tick.
REQ-037 After reset: state=IDLE, TensValue=INIT_TENS, OnesValue=INIT_ONES, Running=0, Expired=0, TimeUp=0, divider=CLOCK_FREQUENCY-1.
REQ-038 Reset asserted on the same edge as Load, Start or a tick SHALL override all of them.

Structure
REQ-039 The shared package SHALL hold the FSM state encoding (2 bits), BCD_MAX=9 and BCD_ZERO=0.
REQ-040 The divider SHALL be a separate sub-module, countdown_tick, with ports Clock, Reset, Run, ReloadReq and Tick.
REQ-041 The divider width SHALL be ceil(log2(CLOCK_FREQUENCY)) bits.

Verification (CLOCK_FREQUENCY=4)
REQ-042 Reset, then Start -> Running=1; ticks every 4 cycles; the value sequence SHALL be 60, 59, 58.
REQ-043 Load 10, then Start -> the values SHALL be 09 after tick 1 and 00 after tick 10; Expired SHALL be one cycle high; TimeUp SHALL be 1; further ticks SHALL not change the value.
REQ-044 Load 25, Start, Pause at divider=2 for 20 cycles, then Start -> the next decrement SHALL occur 2 cycles after resume, and the value SHALL stay 25 during the pause.
REQ-045 Load 0xF3 -> the value SHALL be 93.
REQ-046 Load during RUN -> SHALL be ignored.
REQ-047 Load 00, then Start -> SHALL stay in IDLE with Running=0.
REQ-048 Load 01, Start, and Pause on the tick cycle -> the value SHALL be 00 and the state DONE, with Expired pulsed.
REQ-049 Reset mid-RUN at value 37 -> the next cycle SHALL show value 60, IDLE, all flags 0.
